wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 72 +++++++
 tb/tb_wb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin write-back arbiter sharing one register-file write port among N_REQ one-entry result slots
module wb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int W_DATA = 32,
    parameter int W_REG  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*W_REG-1:0]    req_r_i,
    input  logic [N_REQ*W_DATA-1:0]   req_data_i,
    output logic [N_REQ-1:0]          full_o,
    input  logic                      wb_stall_i,
    output logic                      wb_o,
    output logic [W_REG-1:0]          wb_r_o,
    output logic [W_DATA-1:0]         wb_data_o,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      pending_o
);
    localparam int W_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    logic [N_REQ-1:0]  slot_v, sel;
    logic [W_REG-1:0]  slot_r [N_REQ];
    logic [W_DATA-1:0] slot_d [N_REQ];
    logic [W_PTR-1:0]  ptr, w, j;
    logic              found;
    always_comb begin
        w = '0;
        j = '0;
        found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = W_PTR'((int'(ptr) + i) % N_REQ);
            if (slot_v[j]) begin
                w = j;
                found = 1'b1;
            end
        end
    end
    assign sel       = (found && !wb_stall_i) ? N_REQ'(1) << w : '0;
    assign full_o    = slot_v & ~sel;
    assign pending_o = |slot_v;
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_v    <= '0;
            ptr       <= '0;
            wb_o      <= 1'b0;
            wb_r_o    <= '0;
            wb_data_o <= '0;
            grant_o   <= '0;
            for (int k = 0; k < N_REQ; k++) begin
                slot_r[k] <= '0;
                slot_d[k] <= '0;
            end
        end else begin
            wb_o      <= |sel;
            wb_r_o    <= |sel ? slot_r[w] : '0;
            wb_data_o <= |sel ? slot_d[w] : '0;
            grant_o   <= sel;
            if (|sel)
                ptr <= W_PTR'((int'(w) + 1) % N_REQ);
            // a refill in the drain cycle wins over clearing the slot
            for (int k = 0; k < N_REQ; k++) begin
                if (req_i[k] && !full_o[k]) begin
                    slot_v[k] <= 1'b1;
                    slot_r[k] <= req_r_i[k*W_REG +: W_REG];
                    slot_d[k] <= req_data_i[k*W_DATA +: W_DATA];
                end else if (sel[k]) begin
                    slot_v[k] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table vectors, directed corner sequences and random traffic against a slot/queue reference model
module tb_wb_arbiter;
    logic         clk, rst, stall;
    logic [3:0]   req, full_o, grant_o;
    logic [15:0]  rr;
    logic [127:0] rd;
    logic         wb_o, pending_o;
    logic [3:0]   wb_r_o;
    logic [31:0]  wb_data_o;

    wb_arbiter dut (
        .clk(clk), .rst(rst), .req_i(req), .req_r_i(rr), .req_data_i(rd),
        .full_o(full_o), .wb_stall_i(stall), .wb_o(wb_o), .wb_r_o(wb_r_o),
        .wb_data_o(wb_data_o), .grant_o(grant_o), .pending_o(pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic        model_ok = 1'b0;
    logic [3:0]  m_v = '0;
    logic [3:0]  m_r [4];
    logic [31:0] m_d [4];
    int          m_ptr = 0;
    logic        m_wb = 1'b0;
    logic [3:0]  m_grant = '0, m_wr = '0;
    logic [31:0] m_wd = '0;

    typedef struct {
        logic [3:0]  req;
        logic        stall;
        logic [31:0] base;
        logic [3:0]  full;
        logic        wb;
        logic [3:0]  grant;
        logic [3:0]  r;
        logic [31:0] d;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_bus(input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            rr[k*4 +: 4]   = 4'(k + 1);
            rd[k*32 +: 32] = base + 32'(k);
        end
    endtask

    // one clock: check combinational outputs, advance model and DUT, check registered outputs
    task automatic cycle();
        int win;
        logic [3:0] ef;
        #1;
        win = -1;
        for (int o = 0; o < 4; o++) begin
            if (win < 0 && m_v[(m_ptr + o) % 4]) win = (m_ptr + o) % 4;
        end
        if (stall) win = -1;
        ef = m_v;
        if (win >= 0) ef[win] = 1'b0;
        if (model_ok) begin
            chk("m_full", {60'd0, full_o}, {60'd0, ef});
            chk("m_pending", {63'd0, pending_o}, {63'd0, |m_v});
        end
        @(posedge clk);
        if (!rst) begin
            model_ok = 1'b1;
            m_v = '0; m_ptr = 0; m_wb = 0; m_grant = '0; m_wr = '0; m_wd = '0;
        end else begin
            m_wb = win >= 0;
            m_grant = win >= 0 ? 4'(1 << win) : 4'd0;
            m_wr = win >= 0 ? m_r[win] : 4'd0;
            m_wd = win >= 0 ? m_d[win] : 32'd0;
            if (win >= 0) begin
                m_v[win] = 1'b0;
                m_ptr = (win + 1) % 4;
            end
            for (int k = 0; k < 4; k++) begin
                if (req[k] && !ef[k]) begin
                    m_v[k] = 1'b1;
                    m_r[k] = rr[k*4 +: 4];
                    m_d[k] = rd[k*32 +: 32];
                end
            end
        end
        #1;
        if (model_ok) begin
            chk("m_wb", {63'd0, wb_o}, {63'd0, m_wb});
            chk("m_grant", {60'd0, grant_o}, {60'd0, m_grant});
            chk("m_wr", {60'd0, wb_r_o}, {60'd0, m_wr});
            chk("m_wd", {32'd0, wb_data_o}, {32'd0, m_wd});
        end
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 32'h100, 4'b0000, 1'b0, 4'b0000, 4'd0, 32'h0};
        tbl[1]  = '{4'b0000, 1'b0, 32'h0,   4'b1110, 1'b1, 4'b0001, 4'd1, 32'h100};
        tbl[2]  = '{4'b0000, 1'b0, 32'h0,   4'b1100, 1'b1, 4'b0010, 4'd2, 32'h101};
        tbl[3]  = '{4'b0000, 1'b0, 32'h0,   4'b1000, 1'b1, 4'b0100, 4'd3, 32'h102};
        tbl[4]  = '{4'b0000, 1'b0, 32'h0,   4'b0000, 1'b1, 4'b1000, 4'd4, 32'h103};
        tbl[5]  = '{4'b0000, 1'b0, 32'h0,   4'b0000, 1'b0, 4'b0000, 4'd0, 32'h0};
        tbl[6]  = '{4'b0101, 1'b0, 32'hA00, 4'b0000, 1'b0, 4'b0000, 4'd0, 32'h0};
        tbl[7]  = '{4'b0000, 1'b1, 32'h0,   4'b0101, 1'b0, 4'b0000, 4'd0, 32'h0};
        tbl[8]  = '{4'b0001, 1'b1, 32'hBAD, 4'b0101, 1'b0, 4'b0000, 4'd0, 32'h0};
        tbl[9]  = '{4'b0000, 1'b1, 32'h0,   4'b0101, 1'b0, 4'b0000, 4'd0, 32'h0};
        tbl[10] = '{4'b0000, 1'b0, 32'h0,   4'b0100, 1'b1, 4'b0001, 4'd1, 32'hA00};
        tbl[11] = '{4'b0000, 1'b0, 32'h0,   4'b0000, 1'b1, 4'b0100, 4'd3, 32'hA02};
        tbl[12] = '{4'b1001, 1'b0, 32'hC00, 4'b0000, 1'b0, 4'b0000, 4'd0, 32'h0};
        tbl[13] = '{4'b0000, 1'b0, 32'h0,   4'b0001, 1'b1, 4'b1000, 4'd4, 32'hC03};
        tbl[14] = '{4'b0000, 1'b0, 32'h0,   4'b0000, 1'b1, 4'b0001, 4'd1, 32'hC00};
        tbl[15] = '{4'b0000, 1'b0, 32'h0,   4'b0000, 1'b0, 4'b0000, 4'd0, 32'h0};

        rst = 1'b0; stall = 1'b0; req = '0; rr = '0; rd = '0;
        cycle();
        cycle();
        chk("rst_wb", {63'd0, wb_o}, 64'd0);
        chk("rst_wr", {60'd0, wb_r_o}, 64'd0);
        chk("rst_wd", {32'd0, wb_data_o}, 64'd0);
        chk("rst_grant", {60'd0, grant_o}, 64'd0);
        chk("rst_full", {60'd0, full_o}, 64'd0);
        chk("rst_pending", {63'd0, pending_o}, 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            req = tbl[i].req;
            stall = tbl[i].stall;
            set_bus(tbl[i].base);
            #1;
            chk($sformatf("t%0d_full", i), {60'd0, full_o}, {60'd0, tbl[i].full});
            cycle();
            chk($sformatf("t%0d_wb", i), {63'd0, wb_o}, {63'd0, tbl[i].wb});
            chk($sformatf("t%0d_grant", i), {60'd0, grant_o}, {60'd0, tbl[i].grant});
            chk($sformatf("t%0d_wr", i), {60'd0, wb_r_o}, {60'd0, tbl[i].r});
            chk($sformatf("t%0d_wd", i), {32'd0, wb_data_o}, {32'd0, tbl[i].d});
        end
        stall = 1'b0;

        req = 4'b0010;
        rr[7:4] = 4'd5;
        rd[63:32] = 32'hDEAD_BEEF;
        cycle();
        req = '0;
        chk("single_wait", {63'd0, wb_o}, 64'd0);
        cycle();
        chk("single_wb", {63'd0, wb_o}, 64'd1);
        chk("single_wr", {60'd0, wb_r_o}, 64'd5);
        chk("single_wd", {32'd0, wb_data_o}, 64'hDEAD_BEEF);
        chk("single_grant", {60'd0, grant_o}, 64'b0010);
        cycle();
        chk("single_once", {63'd0, wb_o}, 64'd0);
        chk("single_pending", {63'd0, pending_o}, 64'd0);

        for (int i = 1; i <= 5; i++) begin
            req = 4'b1000;
            rr[15:12] = 4'd7;
            rd[127:96] = 32'(i);
            #1;
            chk("b2b_full3", {63'd0, full_o[3]}, 64'd0);
            cycle();
            if (i > 1) chk("b2b_wd", {32'd0, wb_data_o}, 64'(i - 1));
        end
        req = '0;
        cycle();
        chk("b2b_last", {32'd0, wb_data_o}, 64'd5);
        cycle();
        chk("b2b_idle", {63'd0, wb_o}, 64'd0);

        stall = 1'b1;
        req = 4'b0111;
        set_bus(32'h700);
        cycle();
        req = '0;
        chk("mid_pending", {63'd0, pending_o}, 64'd1);
        rst = 1'b0;
        stall = 1'b0;
        cycle();
        rst = 1'b1;
        chk("mid_wb", {63'd0, wb_o}, 64'd0);
        chk("mid_pending0", {63'd0, pending_o}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("mid_nostale", {63'd0, wb_o}, 64'd0);
        end

        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom_range(0, 15));
            stall = $urandom_range(0, 3) == 0;
            rst = $urandom_range(0, 63) != 0;
            for (int k = 0; k < 4; k++) begin
                rr[k*4 +: 4] = 4'($urandom);
                rd[k*32 +: 32] = $urandom;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
